// File: rtl/axi_16bit_serializer.sv
// axi_16bit_serializer
// Width-down converter: each 16-bit slave word is emitted as two 8-bit master
// beats, the second flagged with m_axis_last. word_count tracks fully emitted
// words and wraps modulo 2^COUNT_WIDTH.
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | no word held, ready to accept a new word
// FIRST  | word held, presenting its first byte
// SECOND | presenting second byte; may accept next word
module axi_16bit_serializer #(
    parameter bit MSB_FIRST   = 1'b0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            s_axis_data,
    input  logic                   s_axis_valid,
    output logic                   s_axis_ready,
    output logic [7:0]             m_axis_data,
    output logic                   m_axis_valid,
    input  logic                   m_axis_ready,
    output logic                   m_axis_last,
    output logic [COUNT_WIDTH-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [15:0]            word;
    logic [COUNT_WIDTH-1:0] count;
    logic                   capture;
    logic                   done;
    logic [7:0]             byte_first;
    logic [7:0]             byte_second;

    assign byte_first  = MSB_FIRST ? word[15:8] : word[7:0];
    assign byte_second = MSB_FIRST ? word[7:0]  : word[15:8];
    assign word_count  = count;

    // Next-state, handshake-derived strobes and port outputs.
    // s_axis_ready in SECOND follows m_axis_ready only, so the slave side
    // can never form a combinational loop through s_axis_valid.
    always_comb begin
        state_nxt    = state;
        s_axis_ready = 1'b0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        m_axis_data  = 8'h00;
        capture      = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                s_axis_ready = !rst;
                if (s_axis_valid && !rst) begin
                    capture   = 1'b1;
                    state_nxt = FIRST;
                end
            end
            FIRST: begin
                m_axis_valid = 1'b1;
                m_axis_data  = byte_first;
                if (m_axis_ready) begin
                    state_nxt = SECOND;
                end
            end
            SECOND: begin
                m_axis_valid = 1'b1;
                m_axis_last  = 1'b1;
                m_axis_data  = byte_second;
                s_axis_ready = m_axis_ready && !rst;
                if (m_axis_ready) begin
                    done = 1'b1;
                    if (s_axis_valid) begin
                        capture   = 1'b1;
                        state_nxt = FIRST;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, held word and completed-word counter; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            word  <= 16'h0000;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                word <= s_axis_data;
            end
            if (done) begin
                count <= count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_axi_16bit_serializer.sv
// Testbench for axi_16bit_serializer. Two instances share the same stimulus:
// dut_a (LSB first, 16-bit counter) and dut_b (MSB first, 4-bit counter).
// A byte-queue model predicts every output each cycle; byte logs captured
// from the master ports are also checked against literal expectations.
module tb_axi_16bit_serializer;

    logic        clk;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        m_ready;

    logic        s_ready_a, m_valid_a, m_last_a;
    logic [7:0]  m_data_a;
    logic [15:0] wc_a;
    logic        s_ready_b, m_valid_b, m_last_b;
    logic [7:0]  m_data_b;
    logic [3:0]  wc_b;

    int n_cmp = 0;
    int n_err = 0;
    bit en = 1'b0;

    // model state: pending bytes per byte order, and counters
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    // bytes actually accepted on each master port
    logic [7:0]  loga[$];
    logic [7:0]  logb[$];
    logic [7:0]  exp_q[$];

    axi_16bit_serializer #(.MSB_FIRST(1'b0), .COUNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_ready(s_ready_a),
        .m_axis_data(m_data_a), .m_axis_valid(m_valid_a), .m_axis_ready(m_ready),
        .m_axis_last(m_last_a), .word_count(wc_a)
    );

    axi_16bit_serializer #(.MSB_FIRST(1'b1), .COUNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_ready(s_ready_b),
        .m_axis_data(m_data_b), .m_axis_valid(m_valid_b), .m_axis_ready(m_ready),
        .m_axis_last(m_last_b), .word_count(wc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string name, input logic [7:0] act[$], input logic [7:0] exp[$]);
        chk({name, "_len"}, 16'(act.size()), 16'(exp.size()));
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            chk($sformatf("%s[%0d]", name, i), {8'h00, act[i]}, {8'h00, exp[i]});
    endtask

    // Per-cycle compare against the model, then advance the model and logs
    // to the state they must hold after the coming rising edge.
    always @(negedge clk) begin
        logic exp_sr;
        logic [7:0] w_lo, w_hi;
        exp_sr = !rst && (qa.size() == 0 || (qa.size() == 1 && m_ready));
        if (en) begin
            chk("s_ready_a", {15'd0, s_ready_a}, {15'd0, exp_sr});
            chk("s_ready_b", {15'd0, s_ready_b}, {15'd0, exp_sr});
            chk("m_valid_a", {15'd0, m_valid_a}, {15'd0, qa.size() != 0});
            chk("m_valid_b", {15'd0, m_valid_b}, {15'd0, qb.size() != 0});
            chk("m_last_a", {15'd0, m_last_a}, {15'd0, qa.size() == 1});
            chk("m_last_b", {15'd0, m_last_b}, {15'd0, qb.size() == 1});
            chk("m_data_a", {8'h00, m_data_a}, {8'h00, (qa.size() != 0) ? qa[0] : 8'h00});
            chk("m_data_b", {8'h00, m_data_b}, {8'h00, (qb.size() != 0) ? qb[0] : 8'h00});
            chk("word_count_a", wc_a, cnt_a);
            chk("word_count_b", {12'd0, wc_b}, {12'd0, cnt_b});
        end
        if (!rst && m_valid_a && m_ready) loga.push_back(m_data_a);
        if (!rst && m_valid_b && m_ready) logb.push_back(m_data_b);
        if (rst) begin
            qa.delete();
            qb.delete();
            cnt_a = 16'd0;
            cnt_b = 4'd0;
        end else begin
            if (qa.size() != 0 && m_ready) begin
                if (qa.size() == 1) begin
                    cnt_a = cnt_a + 16'd1;
                    cnt_b = cnt_b + 4'd1;
                end
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (s_valid && exp_sr) begin
                w_lo = s_data[7:0];
                w_hi = s_data[15:8];
                qa.push_back(w_lo); qa.push_back(w_hi);
                qb.push_back(w_hi); qb.push_back(w_lo);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a word and hold it until the slave handshake edge.
    task automatic push_word(input logic [15:0] w);
        bit acc;
        acc = 1'b0;
        s_data  = w;
        s_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = s_ready_a;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: word %h not accepted within 20 cycles", w);
        end
        s_valid = 1'b0;
    endtask

    task automatic clear_logs();
        loga.delete();
        logb.delete();
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = 16'h0000;
        cnt_a = 16'd0; cnt_b = 4'd0;
        cyc(2);
        en = 1'b1;
        cyc(1);
        rst = 1'b0;

        // single word, LSB first on dut_a, MSB first on dut_b
        clear_logs();
        m_ready = 1'b1;
        push_word(16'hA55A);
        cyc(3);
        exp_q = '{8'h5A, 8'hA5}; chk_log("single_a", loga, exp_q);
        exp_q = '{8'hA5, 8'h5A}; chk_log("single_b", logb, exp_q);
        chk("single_wc", wc_a, 16'd1);

        // back-to-back streaming
        clear_logs();
        push_word(16'h0102);
        push_word(16'h0304);
        push_word(16'h0506);
        cyc(3);
        exp_q = '{8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05}; chk_log("stream_a", loga, exp_q);
        chk("stream_wc", wc_a, 16'd4);

        // back-pressure: 3 stalls in FIRST, 2 in SECOND
        clear_logs();
        m_ready = 1'b0;
        push_word(16'hBEEF);
        cyc(3);
        m_ready = 1'b1; cyc(1);
        m_ready = 1'b0; cyc(2);
        m_ready = 1'b1; cyc(3);
        exp_q = '{8'hEF, 8'hBE}; chk_log("bp_a", loga, exp_q);

        // MSB-first ordering
        clear_logs();
        push_word(16'h1234);
        cyc(3);
        exp_q = '{8'h12, 8'h34}; chk_log("msb_b", logb, exp_q);
        exp_q = '{8'h34, 8'h12}; chk_log("msb_a", loga, exp_q);

        // counter wrap on the 4-bit instance
        rst = 1'b1; cyc(1); rst = 1'b0;
        for (int i = 0; i < 15; i++) push_word(16'(i * 16'h0101));
        cyc(3);
        chk("wrap_15", {12'd0, wc_b}, 16'd15);
        push_word(16'h7777); cyc(3);
        chk("wrap_0", {12'd0, wc_b}, 16'd0);
        push_word(16'h8888); cyc(3);
        chk("wrap_1", {12'd0, wc_b}, 16'd1);
        chk("wrap_wide", wc_a, 16'd17);

        // reset coinciding with the last-beat handshake
        clear_logs();
        m_ready = 1'b0;
        push_word(16'hCAFE);
        m_ready = 1'b1; cyc(1);
        rst = 1'b1; cyc(1);
        rst = 1'b0; m_ready = 1'b0;
        cyc(1);
        chk("rst_valid", {15'd0, m_valid_a}, 16'd0);
        chk("rst_wc", wc_a, 16'd0);
        m_ready = 1'b1;
        push_word(16'h1111);
        cyc(3);
        exp_q = '{8'hFE, 8'h11, 8'h11}; chk_log("rst_a", loga, exp_q);
        chk("rst_wc_after", wc_a, 16'd1);

        en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_16bit_serializer.md
# axi_16bit_serializer

Width-down converter on the AXI-stream-style valid/ready handshake: accepts 16-bit words on a slave port and emits each as two 8-bit beats on a master port, with a last-beat flag and a completed-word counter. Sits where a 16-bit result stream (e.g. adder sum output) must be fed into an 8-bit consumer or link. Sustains one byte per cycle under continuous back-pressure-free traffic, with no bubble between words.

## Interface
- MSB_FIRST, 0, byte order: 0 = low byte [7:0] first, 1 = high byte [15:8] first
- COUNT_WIDTH, 16, width of completed-word counter
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- s_axis_data  input  16  input word
- s_axis_valid  input  1  input word valid
- s_axis_ready  output  1  serializer can accept word this cycle
- m_axis_data  output  8  output byte
- m_axis_valid  output  1  output byte valid
- m_axis_ready  input  1  downstream accepts byte
- m_axis_last  output  1  high on second (final) beat of a word
- word_count  output  COUNT_WIDTH  number of words fully emitted, wrapping

## Operation
- Handshake on either port completes at a rising edge where valid && ready are both high.
- States: IDLE (no word held), FIRST (word held, presenting first byte), SECOND (presenting second byte).
- Word register W (16 bits) captured on every slave handshake.
- IDLE: s_axis_ready=1, m_axis_valid=0. Slave handshake -> capture W, go FIRST.
- FIRST: s_axis_ready=0, m_axis_valid=1, m_axis_last=0, m_axis_data = first byte of W. Master handshake -> SECOND; else hold.
- SECOND: m_axis_valid=1, m_axis_last=1, m_axis_data = second byte of W. s_axis_ready = m_axis_ready (combinational from m_axis_ready only, never from s_axis_valid). Master handshake: word_count increments; if slave handshake same edge -> capture new W, go FIRST; else -> IDLE. No master handshake -> hold, no slave handshake.
- First/second byte: MSB_FIRST=0 -> W[7:0] then W[15:8]; MSB_FIRST=1 -> W[15:8] then W[7:0].
- m_axis_data/m_axis_last stable while m_axis_valid && !m_axis_ready; m_axis_valid never drops without a master handshake.
- m_axis_data = 0 and m_axis_last = 0 in IDLE.
- word_count: modulo 2^COUNT_WIDTH, all-ones + 1 -> 0, no saturation.
- s_axis_data ignored when no slave handshake occurs.

## Timing
- Reset (rst high at an edge): state IDLE, W=0, word_count=0; outputs m_axis_valid=0, m_axis_data=0, m_axis_last=0. s_axis_ready forced 0 while rst is high; 1 in first cycle after rst deasserts.
- Reset mid-word: held word discarded, no further beats, word_count cleared; no partial-word recovery.
- Latency: slave handshake at edge N -> first byte valid during cycle after N (edge N+1 earliest master handshake); second byte handshake earliest edge N+2.
- Throughput: with s_axis_valid and m_axis_ready held high, one byte per cycle, new word accepted on same edge as previous word's last beat; s_axis_ready pulses high one cycle in two.
- word_count updates on edge of last-beat handshake; visible the following cycle.
- Simultaneous last-beat handshake and rst: rst wins, word_count=0.

## Test plan
- Single word, MSB_FIRST=0: send 0xA55A, m_axis_ready=1 -> bytes 0x5A (last=0) then 0xA5 (last=1) on consecutive cycles, word_count 0->1, s_axis_ready low during FIRST.
- Streaming: words 0x0102, 0x0304, 0x0506 back-to-back, ready always 1 -> byte stream 02,01,04,03,06,05 with no idle cycle, last on every second beat, word_count=3.
- Back-pressure: send 0xBEEF, m_axis_ready low 3 cycles in FIRST and 2 cycles in SECOND -> 0xEF then 0xBE held stable with valid high throughout, exactly two handshakes, s_axis_ready low until SECOND handshake cycle.
- MSB_FIRST=1: send 0x1234 -> 0x12 then 0x34, last on 0x34.
- Counter wrap, COUNT_WIDTH=4: send 17 words -> word_count sequence ends 15,0,1.
- Reset mid-word: accept 0xCAFE, emit 0xFE, assert rst one cycle before 0xCA handshake -> m_axis_valid=0, word_count=0 next cycle, 0xCA never emitted; next word 0x1111 emits normally.
